// File: rtl/key_pkg.sv
// Shared types and default timing for the push-button conditioner.
package key_pkg;

  // Number of push-buttons handled by the conditioner.
  localparam int NUM_KEYS = 4;

  // Default timing at 50 MHz: 20 ms debounce, 500 ms first repeat, 100 ms repeat period.
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_RATE     = 5000000;

  // Per-key auto-repeat state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Larger of two integers.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One push-button: 2-flop synchronizer, debounce counter and auto-repeat FSM.
// All outputs are registered; press/release/step are single-cycle pulses.
module key_channel
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  input  logic repeat_en,
  output logic pressed,
  output logic press,
  output logic release_pulse,
  output logic step
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam int TW = cnt_width(max2(REPEAT_DELAY, REPEAT_RATE));
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DELAY_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RATE_LAST  = TW'(REPEAT_RATE - 1);

  logic          sync_a;
  logic          sync_b;
  logic          key_level;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          toggle;
  logic          pressed_next;
  logic          repeat_fire;
  rep_state_t    state;
  rep_state_t    state_next;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_next;

  // Two-flop synchronizer; resets to the released (high) level.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
    end else begin
      sync_a <= key_n;
      sync_b <= sync_a;
    end
  end

  assign key_level = ~sync_b;

  // Debounce: count consecutive disagreeing cycles, flip the level on the last one.
  always_comb begin
    cnt_next     = '0;
    toggle       = 1'b0;
    pressed_next = pressed;
    if (key_level != pressed) begin
      if (cnt == CNT_LAST) begin
        toggle       = 1'b1;
        pressed_next = ~pressed;
        cnt_next     = '0;
      end else begin
        cnt_next = cnt + CW'(1);
      end
    end else begin
      cnt_next = '0;
    end
  end

  // Repeat FSM next state; a falling level or disabled repeat always wins over a pulse.
  // A repeat pulse is suppressed if step is already high so step never lasts two cycles.
  always_comb begin
    state_next  = state;
    timer_next  = timer;
    repeat_fire = 1'b0;
    if (!pressed_next || !repeat_en) begin
      state_next = IDLE;
      timer_next = '0;
    end else begin
      case (state)
        IDLE: begin
          timer_next = '0;
          if (toggle) begin
            state_next = DELAY;
          end else begin
            state_next = IDLE;
          end
        end
        DELAY: begin
          if (timer == DELAY_LAST) begin
            repeat_fire = ~step;
            state_next  = REPEAT;
            timer_next  = '0;
          end else begin
            timer_next = timer + TW'(1);
          end
        end
        REPEAT: begin
          if (timer == RATE_LAST) begin
            repeat_fire = ~step;
            timer_next  = '0;
          end else begin
            timer_next = timer + TW'(1);
          end
        end
        default: begin
          state_next = IDLE;
          timer_next = '0;
        end
      endcase
    end
  end

  // Debounced level, counter and registered output pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt           <= '0;
      pressed       <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      step          <= 1'b0;
    end else begin
      cnt           <= cnt_next;
      pressed       <= pressed_next;
      press         <= toggle & pressed_next;
      release_pulse <= toggle & ~pressed_next;
      step          <= (toggle & pressed_next) | repeat_fire;
    end
  end

  // Repeat FSM state and timer register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Four independent push-button conditioners: debounced level, press/release
// pulses and an auto-repeating step pulse per key.
module key_conditioner
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic [NUM_KEYS-1:0] KEY,
  input  logic [NUM_KEYS-1:0] REPEAT_EN,
  output logic [NUM_KEYS-1:0] PRESSED,
  output logic [NUM_KEYS-1:0] PRESS,
  output logic [NUM_KEYS-1:0] RELEASE,
  output logic [NUM_KEYS-1:0] STEP
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_channel (
      .clk          (CLOCK_50),
      .reset_n      (RESET_N),
      .key_n        (KEY[i]),
      .repeat_en    (REPEAT_EN[i]),
      .pressed      (PRESSED[i]),
      .press        (PRESS[i]),
      .release_pulse(RELEASE[i]),
      .step         (STEP[i])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_RATE=3. Stimulus pushes expected pulse events (cycle stamped); the
// monitor pops and compares whenever any PRESS/RELEASE/STEP bit is high.
module tb_key_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key;
  logic [3:0] ren;
  logic [3:0] pressed;
  logic [3:0] press;
  logic [3:0] rel;
  logic [3:0] step;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] step;
    logic [3:0] pressed;
  } ev_t;

  ev_t q[$];
  ev_t mon_e;

  key_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_RATE    (3)
  ) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .KEY      (key),
    .REPEAT_EN(ren),
    .PRESSED  (pressed),
    .PRESS    (press),
    .RELEASE  (rel),
    .STEP     (step)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every observed pulse must match the next expected event.
  always @(negedge clk) begin
    if (mon_en && ((press | rel | step) != 4'b0000)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: cycle=%0d press=%b release=%b step=%b pressed=%b, required no pulse",
                 cyc, press, rel, step, pressed);
      end else begin
        mon_e = q.pop_front();
        if (mon_e.cyc != cyc || mon_e.press !== press || mon_e.rel !== rel ||
            mon_e.step !== step || mon_e.pressed !== pressed) begin
          errors++;
          $display("FAIL event: got cycle=%0d press=%b release=%b step=%b pressed=%b, required cycle=%0d press=%b release=%b step=%b pressed=%b",
                   cyc, press, rel, step, pressed,
                   mon_e.cyc, mon_e.press, mon_e.rel, mon_e.step, mon_e.pressed);
        end
      end
    end
  end

  task automatic push_ev(input int c, input logic [3:0] pr, input logic [3:0] rl,
                         input logic [3:0] st, input logic [3:0] pd);
    ev_t e;
    e.cyc     = c;
    e.press   = pr;
    e.rel     = rl;
    e.step    = st;
    e.pressed = pd;
    q.push_back(e);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_vec(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Every expected event must have been consumed by the monitor.
  task automatic drain(input string name);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_events: got %0d pending required 0 (next at cycle %0d)",
               name, q.size(), q[0].cyc);
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n = 1'b0;
    key   = 4'hF;
    ren   = 4'h0;
    @(posedge clk);
    #1;
    wait_to(3);
    check_vec("reset_outputs", {pressed, press, rel, step}, 16'h0000);
    rst_n = 1'b1;
    wait_to(6);
    mon_en = 1'b1;

    // Single press without repeat, latency boundary.
    base = cyc;
    push_ev(base + 6,  4'b0010, 4'b0000, 4'b0010, 4'b0010);
    push_ev(base + 46, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    key[1] = 1'b0;
    wait_to(base + 5);
    check_vec("s1_pressed_c5", {12'h000, pressed}, 16'h0000);
    wait_to(base + 6);
    check_vec("s1_pressed_c6", {12'h000, pressed}, 16'h0002);
    wait_to(base + 40);
    key[1] = 1'b1;
    wait_to(base + 55);
    drain("s1");

    // 3-cycle glitch is rejected.
    base = cyc;
    key[0] = 1'b0;
    wait_to(base + 3);
    key[0] = 1'b1;
    wait_to(base + 12);
    check_vec("s2_glitch_pressed", {12'h000, pressed}, 16'h0000);
    drain("s2");

    // 4-cycle low is accepted; 4 released cycles release it.
    base = cyc;
    push_ev(base + 6,  4'b0001, 4'b0000, 4'b0001, 4'b0001);
    push_ev(base + 10, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    key[0] = 1'b0;
    wait_to(base + 4);
    key[0] = 1'b1;
    wait_to(base + 18);
    drain("s2b");

    // Auto-repeat; hold 31 makes release coincide with a due repeat pulse.
    for (int hold = 30; hold <= 31; hold++) begin
      ren  = 4'b0100;
      base = cyc;
      push_ev(base + 6, 4'b0100, 4'b0000, 4'b0100, 4'b0100);
      for (int t = 16; t < hold + 6; t += 3) begin
        push_ev(base + t, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
      end
      push_ev(base + hold + 6, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
      key[2] = 1'b0;
      wait_to(base + hold);
      key[2] = 1'b1;
      wait_to(base + hold + 15);
      drain("s3");
      ren = 4'b0000;
    end

    // Repeat disabled mid-hold; re-enabling while held does not restart it.
    ren  = 4'b0100;
    base = cyc;
    push_ev(base + 6,  4'b0100, 4'b0000, 4'b0100, 4'b0100);
    push_ev(base + 16, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    push_ev(base + 36, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
    key[2] = 1'b0;
    wait_to(base + 17);
    ren[2] = 1'b0;
    wait_to(base + 20);
    ren[2] = 1'b1;
    wait_to(base + 25);
    check_vec("s4_pressed_held", {12'h000, pressed}, 16'h0004);
    wait_to(base + 30);
    key[2] = 1'b1;
    wait_to(base + 45);
    drain("s4");
    ren = 4'b0000;

    // Reset while KEY[3] is held: new press after reset release.
    base = cyc;
    push_ev(base + 6,  4'b1000, 4'b0000, 4'b1000, 4'b1000);
    push_ev(base + 20, 4'b1000, 4'b0000, 4'b1000, 4'b1000);
    push_ev(base + 36, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
    key[3] = 1'b0;
    wait_to(base + 12);
    rst_n = 1'b0;
    wait_to(base + 13);
    check_vec("s5_reset_c13", {pressed, press, rel, step}, 16'h0000);
    wait_to(base + 14);
    check_vec("s5_reset_c14", {pressed, press, rel, step}, 16'h0000);
    rst_n = 1'b1;
    wait_to(base + 19);
    check_vec("s5_pressed_c19", {12'h000, pressed}, 16'h0000);
    wait_to(base + 30);
    key[3] = 1'b1;
    wait_to(base + 45);
    drain("s5");

    // Simultaneous presses of KEY[1] and KEY[2].
    base = cyc;
    push_ev(base + 6,  4'b0110, 4'b0000, 4'b0110, 4'b0110);
    push_ev(base + 16, 4'b0000, 4'b0110, 4'b0000, 4'b0000);
    key[2:1] = 2'b00;
    wait_to(base + 10);
    key = 4'hF;
    wait_to(base + 25);
    drain("s6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
